// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - shared constants, state types and word formatting for the ADC capture path
package adc_capture_pkg;

    localparam int FRAME_BITS = 32;
    localparam int HDR_BITS   = 8;
    localparam int DATA_BITS  = 24;
    localparam int ERR_BIT    = 7;

    typedef enum logic [1:0] {IDLE, ARMED, SHIFT} rx_state_t;
    typedef enum logic {E_IDLE, E_SCAN} emit_state_t;

    // 24-bit mode passes the data field through; 16-bit mode keeps its top 16 bits right-aligned
    function automatic logic [DATA_BITS-1:0] format_word(input logic [FRAME_BITS-1:0] frame,
                                                         input logic mode_24b);
        if (mode_24b)
            return frame[DATA_BITS-1:0];
        return {{HDR_BITS{1'b0}}, frame[DATA_BITS-1:HDR_BITS]};
    endfunction

    // Error flag carried in the frame header
    function automatic logic hdr_err(input logic [FRAME_BITS-1:0] frame);
        return frame[DATA_BITS + ERR_BIT];
    endfunction

endpackage

// File: rtl/adc_frame_deser.sv
// rtl/adc_frame_deser.sv - synchronises the ADC pins and deserialises one 32-bit frame per lane
module adc_frame_deser
    import adc_capture_pkg::*;
#(
    parameter int NUM_CH = 4
)
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            adc_data,
    input  logic                         adc_n_drdy,
    input  logic                         adc_dclk,
    input  logic                         acq_en,
    output logic [NUM_CH*FRAME_BITS-1:0] hold,
    output logic                         frame_done,
    output logic                         frame_err
);

    logic [NUM_CH-1:0] data_s1, data_s2;
    logic              drdy_s1, drdy_s2, drdy_d;
    logic              dclk_s1, dclk_s2, dclk_d;
    logic              drdy_rise, dclk_fall;

    // Only the 31 earlier bits need storing; the 32nd comes straight from the lane
    logic [NUM_CH-1:0][FRAME_BITS-2:0] sr;
    logic [5:0]                        bit_cnt;

    rx_state_t rx_state, rx_next;
    logic      clr_cnt, shift_en, done_d, err_d;

    // Two-stage synchronisers; lanes share the strobe delay so bits line up with the DCLK edge
    always_ff @(posedge clk) begin
        if (reset) begin
            data_s1 <= '0;
            data_s2 <= '0;
            drdy_s1 <= 1'b0;
            drdy_s2 <= 1'b0;
            drdy_d  <= 1'b0;
            dclk_s1 <= 1'b0;
            dclk_s2 <= 1'b0;
            dclk_d  <= 1'b0;
        end else begin
            data_s1 <= adc_data;
            data_s2 <= data_s1;
            drdy_s1 <= adc_n_drdy;
            drdy_s2 <= drdy_s1;
            drdy_d  <= drdy_s2;
            dclk_s1 <= adc_dclk;
            dclk_s2 <= dclk_s1;
            dclk_d  <= dclk_s2;
        end
    end

    assign drdy_rise = drdy_s2 & ~drdy_d;
    assign dclk_fall = dclk_d & ~dclk_s2;

    // Receive state register
    always_ff @(posedge clk) begin
        if (reset)
            rx_state <= IDLE;
        else
            rx_state <= rx_next;
    end

    // Receive next-state: arm on frame marker, shift on DCLK fall, abort on an early marker
    always_comb begin
        rx_next  = rx_state;
        clr_cnt  = 1'b0;
        shift_en = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (rx_state)
            IDLE: begin
                if (drdy_rise && acq_en) begin
                    rx_next = ARMED;
                    clr_cnt = 1'b1;
                end
            end
            ARMED: begin
                if (dclk_fall) begin
                    shift_en = 1'b1;
                    rx_next  = SHIFT;
                end
            end
            SHIFT: begin
                if (drdy_rise) begin
                    err_d   = 1'b1;
                    clr_cnt = 1'b1;
                    rx_next = acq_en ? ARMED : IDLE;
                end else if (dclk_fall) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 6'(FRAME_BITS - 1)) begin
                        done_d  = 1'b1;
                        rx_next = IDLE;
                    end
                end
            end
            default: rx_next = IDLE;
        endcase
    end

    // Shift registers, bit counter, holding registers and the frame pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            sr         <= '0;
            bit_cnt    <= '0;
            hold       <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= done_d;
            frame_err  <= err_d;
            if (clr_cnt)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + 6'd1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (shift_en)
                    sr[i] <= {sr[i][FRAME_BITS-3:0], data_s2[i]};
                if (done_d)
                    hold[i*FRAME_BITS +: FRAME_BITS] <= {sr[i], data_s2[i]};
            end
        end
    end

endmodule

// File: rtl/adc_capture_mc.sv
// rtl/adc_capture_mc.sv - ADC clock/reset generation, frame capture and per-channel FIFO emission
module adc_capture_mc
    import adc_capture_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CLK_DIV = 4,
    parameter int OUT_W   = 24,
    parameter int CNT_W   = 16
)
(
    input  logic              clk,
    input  logic              reset,
    output logic              adc_clk,
    output logic              adc_n_reset,
    input  logic [NUM_CH-1:0] adc_data,
    input  logic              adc_n_drdy,
    input  logic              adc_dclk,
    input  logic              acq_en,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              mode_24b,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [OUT_W-1:0]  fifo_din,
    output logic [2:0]        fifo_ch,
    output logic [CNT_W-1:0]  overflow_cnt,
    output logic [CNT_W-1:0]  frame_err_cnt,
    output logic              adc_err
);

    localparam int HALF_DIV = CLK_DIV / 2;
    localparam int DIV_W    = $clog2(HALF_DIV) + 1;

    logic [DIV_W-1:0]              div_cnt;
    logic [NUM_CH*FRAME_BITS-1:0]  hold;
    logic                          frame_done, frame_err;

    emit_state_t            emit_state, emit_next;
    logic [NUM_CH-1:0]      pending, pending_next, scan_mask;
    logic [2:0]             sel;
    logic [FRAME_BITS-1:0]  sel_frame;
    logic                   word_mode, mode_q;
    logic                   word_valid;
    logic                   err_seen;
    logic                   start;

    adc_frame_deser #(.NUM_CH(NUM_CH)) u_deser (
        .clk        (clk),
        .reset      (reset),
        .adc_data   (adc_data),
        .adc_n_drdy (adc_n_drdy),
        .adc_dclk   (adc_dclk),
        .acq_en     (acq_en),
        .hold       (hold),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    // MCLK divider: toggles every HALF_DIV clks, restarting low after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            adc_clk <= 1'b0;
        end else if (div_cnt == DIV_W'(HALF_DIV - 1)) begin
            div_cnt <= '0;
            adc_clk <= ~adc_clk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // ADC reset is held low exactly while system reset is asserted
    always_ff @(posedge clk) begin
        if (reset)
            adc_n_reset <= 1'b0;
        else
            adc_n_reset <= 1'b1;
    end

    // Emit state register
    always_ff @(posedge clk) begin
        if (reset)
            emit_state <= E_IDLE;
        else
            emit_state <= emit_next;
    end

    // Emit scan: pick the lowest pending channel each clk; disabled channels never enter the mask
    always_comb begin
        start     = (emit_state == E_IDLE) && frame_done;
        scan_mask = '0;
        if (emit_state == E_SCAN)
            scan_mask = pending;
        else if (frame_done)
            scan_mask = ch_en;
        word_mode = start ? mode_24b : mode_q;
        sel       = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (scan_mask[i])
                sel = 3'(i);
        sel_frame = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (sel == 3'(i))
                sel_frame = hold[i*FRAME_BITS +: FRAME_BITS];
        pending_next = scan_mask & (scan_mask - NUM_CH'(1));
        emit_next    = (|pending_next) ? E_SCAN : E_IDLE;
        err_seen     = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            if (ch_en[i] && hdr_err(hold[i*FRAME_BITS +: FRAME_BITS]))
                err_seen = 1'b1;
    end

    // Registered word, channel tag and scan bookkeeping; the word appears one clk after frame_done
    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '0;
            word_valid <= 1'b0;
            fifo_din   <= '0;
            fifo_ch    <= '0;
            mode_q     <= 1'b0;
        end else begin
            pending    <= pending_next;
            word_valid <= |scan_mask;
            if (|scan_mask) begin
                fifo_din <= OUT_W'(format_word(sel_frame, word_mode));
                fifo_ch  <= sel;
            end
            if (start)
                mode_q <= mode_24b;
        end
    end

    // A presented word is written unless the FIFO is full in that same clk
    assign fifo_wr_en = word_valid & ~fifo_full;

    // Saturating drop/abort counters and the sticky header error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_cnt  <= '0;
            frame_err_cnt <= '0;
            adc_err       <= 1'b0;
        end else begin
            if (word_valid && fifo_full && overflow_cnt != {CNT_W{1'b1}})
                overflow_cnt <= overflow_cnt + CNT_W'(1);
            if (frame_err && frame_err_cnt != {CNT_W{1'b1}})
                frame_err_cnt <= frame_err_cnt + CNT_W'(1);
            if (start && err_seen)
                adc_err <= 1'b1;
        end
    end

endmodule

// File: doc/adc_capture_mc.md
Name: adc_capture_mc

Overview:
- Parametrised successor to the AD7768 capture path.
- Generates the ADC master clock and reset, and deserialises NUM_CH data lanes framed by nDRDY/DCLK, all in the single clk domain.
- Strips the 8-bit header and emits one parallel word per enabled channel to the output FIFO, with 16- or 24-bit mode, channel tags, and overflow/error accounting.
- Sits between the ADC pins and the acquisition FIFO feeding the host SPI.

Parameters:
- NUM_CH, 4, number of ADC data lanes (1..8).
- CLK_DIV, 4, clk-to-adc_clk divide ratio (even, >=4).
- OUT_W, 24, output data word width (fixed >=24).
- CNT_W, 16, width of the saturating overflow and frame-error counters.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-high.
- adc_clk  out  1  ADC MCLK, clk/CLK_DIV, 50% duty.
- adc_n_reset  out  1  ADC reset, active-low.
- adc_data  in  NUM_CH  serial lanes, MSB first.
- adc_n_drdy  in  1  frame marker from ADC.
- adc_dclk  in  1  ADC data clock.
- acq_en  in  1  acquisition enable from control.
- ch_en  in  NUM_CH  per-channel emit enable.
- mode_24b  in  1  1 = 24-bit samples, 0 = top 16 bits.
- fifo_full  in  1  downstream FIFO full.
- fifo_wr_en  out  1  write strobe, one clk per word.
- fifo_din  out  OUT_W  sample word.
- fifo_ch  out  3  channel index of fifo_din.
- overflow_cnt  out  CNT_W  words dropped on full, saturating.
- frame_err_cnt  out  CNT_W  aborted frames, saturating.
- adc_err  out  1  sticky, set when a header error bit is seen.

Behaviour:
- Reset values: adc_clk 0, adc_n_reset 0, fifo_wr_en 0, fifo_din 0, fifo_ch 0, both counters 0, adc_err 0, FSM IDLE.
- adc_n_reset goes to 1 on the first clk after reset deasserts.
- adc_clk divider toggles every CLK_DIV/2 clks and restarts from 0 on reset.
- Input synchronisation:
  - adc_data, adc_n_drdy and adc_dclk each pass through a 2-FF synchroniser.
  - DCLK falling and nDRDY rising are detected on the synchronised versions.
  - Data lanes use the same delay, so sampling is coherent with the DCLK edge.
- Receive FSM:
  - IDLE -> ARMED on synced nDRDY rise when acq_en=1. acq_en is sampled only here.
  - ARMED/SHIFT: on each DCLK fall, shift one bit per lane into a 32-bit shift register, MSB first, and increment bit_cnt.
  - When bit_cnt reaches 32, copy all shift registers into holding registers, pulse frame_done, and go to IDLE.
  - nDRDY rise while in SHIFT with bit_cnt in 1..31: abort the frame, increment frame_err_cnt, re-enter ARMED if acq_en=1 (else IDLE). Nothing is emitted for the aborted frame.
  - acq_en deasserted mid-frame: the current frame completes and is emitted, then the FSM stays IDLE.
- Word format, per 32-bit frame:
  - Header = bits[31:24], data = bits[23:0].
  - mode_24b=1: fifo_din = data.
  - mode_24b=0: fifo_din = {8'h00, data[23:8]} (zero-extended).
  - mode_24b is sampled at frame_done.
- Emit FSM:
  - On frame_done, scan channels 0..NUM_CH-1 in order, one clk per enabled channel; disabled channels take zero cycles.
  - Word emission latency: first word 1 clk after frame_done.
  - Each emitted word drives fifo_wr_en=1 for one clk with fifo_din and fifo_ch valid in the same clk.
  - If fifo_full=1 in that clk, fifo_wr_en stays 0, the word is dropped, and overflow_cnt increments (saturating at all-ones).
  - ch_en is sampled at frame_done. ch_en=0 for all channels means nothing is emitted.
- Emit is guaranteed to finish before the next frame_done, since NUM_CH <= 8 < 32*CLK_DIV. The holding registers are therefore never overwritten mid-emit.
- adc_err is set if header bit 7 is 1 for any enabled channel at frame_done. It clears only on reset.
- Any cycle with reset=1 returns every output and FSM to its reset value, regardless of state.

Decomposition:
- Package adc_capture_pkg:
  - FRAME_BITS=32, HDR_BITS=8, DATA_BITS=24, ERR_BIT=7.
  - Receive state enum {IDLE, ARMED, SHIFT}.
  - Emit state enum {E_IDLE, E_SCAN}.
- Sub-module adc_frame_deser: synchronisers, edge detect, receive FSM, shift/holding registers, frame_done and frame_err pulses.
- Top level: clock/reset generation, emit FSM, formatting, counters.

Test Plan:
- Single frame, NUM_CH=4, mode_24b=1, ch_en=4'hF, lanes carry 32'h00ABCDEF, 32'h00123456, 32'h00000001, 32'h00FFFFFF -> 4 consecutive wr_en pulses, fifo_ch 0..3, exactly those 24-bit data values.
- mode_24b=0, ch_en=4'b1010, ch1 = 32'h00ABCDEF, ch3 = 32'h00800000 -> two words: 24'h00ABCD (ch1), then 24'h008000 (ch3).
- fifo_full=1 during the 2nd and 3rd words of a 4-channel frame -> only ch0 and ch3 written, overflow_cnt=2. With fifo_full held high continuously, overflow_cnt saturates at 16'hFFFF.
- nDRDY re-rises after 10 bits -> frame_err_cnt=1, no writes; the next full frame emits correctly.
- ch2 header = 8'h80 -> adc_err=1 and data still emitted; with ch2 disabled, the same header leaves adc_err=0.
- acq_en dropped at bit 16, then reset asserted mid-emit of a later frame -> first frame fully emitted, then no writes; reset returns all outputs to 0 and adc_n_reset to 0 for the reset cycle.
